// File: rtl/spi_pwm_master.sv
// SPI mode-0 master for a register-mapped port expander: one CS-low frame per
// accepted command, MSB-first transmit with simultaneous MSB-first receive.
module spi_pwm_master #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FRAME_BITS = 16
) (
    input  logic                  MainCLK,
    input  logic                  RST,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [FRAME_BITS-1:0] cmd_data,
    output logic                  CS,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        GAP
    } state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [FRAME_BITS-1:0]   tx_sr_q, tx_sr_d;
    logic [FRAME_BITS-1:0]   rx_sr_q, rx_sr_d;
    logic [FRAME_BITS-1:0]   rx_data_q, rx_data_d;
    logic                    cs_q, cs_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    div_end;
    logic                    bit_end;

    assign div_end = (div_q == DIV_LAST);
    assign bit_end = (bit_q == BIT_LAST);

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge MainCLK) begin
        if (RST) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        ready_d    = ready_q;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    tx_sr_d = cmd_data;
                    mosi_d  = cmd_data[FRAME_BITS-1];
                    cs_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = LEAD;
                end
            end

            LEAD: begin
                if (div_end) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    rx_sr_d = {rx_sr_q[FRAME_BITS-2:0], MISO};
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            // High phase ends with a falling edge; low phase ends with the next rise or TRAIL.
            SHIFT: begin
                if (div_end) begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_end) begin
                            mosi_d = 1'b0;
                        end else begin
                            tx_sr_d = {tx_sr_q[FRAME_BITS-2:0], 1'b0};
                            mosi_d  = tx_sr_q[FRAME_BITS-2];
                        end
                    end else if (bit_end) begin
                        state_d = TRAIL;
                    end else begin
                        sclk_d  = 1'b1;
                        bit_d   = bit_q + BIT_W'(1);
                        rx_sr_d = {rx_sr_q[FRAME_BITS-2:0], MISO};
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            TRAIL: begin
                if (div_end) begin
                    div_d      = '0;
                    cs_d       = 1'b1;
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                    state_d    = GAP;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            GAP: begin
                if (div_end) begin
                    div_d   = '0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                div_d   = '0;
                bit_d   = '0;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign CS        = cs_q;
    assign SCLK      = sclk_q;
    assign MOSI      = mosi_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;

endmodule

// File: tb/tb_spi_pwm_master.sv
// Directed bench for spi_pwm_master: a mode-0 slave model drives MISO, and
// scoreboard queues hold the expected MOSI frames and received words.
module tb_spi_pwm_master;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CS_LOW_CYC = (2 * FRAME_BITS + 2) * CLK_DIV;
    localparam int unsigned HS_CYC     = (2 * FRAME_BITS + 3) * CLK_DIV + 1;

    logic        MainCLK   = 1'b0;
    logic        RST       = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_data  = 16'h0000;
    logic        MISO      = 1'b0;
    logic        cmd_ready;
    logic        CS;
    logic        SCLK;
    logic        MOSI;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_tx_q[$];
    logic [15:0] exp_rx_q[$];
    logic [15:0] miso_q[$];

    logic        prev_cs       = 1'b1;
    logic        prev_sclk     = 1'b0;
    logic        prev_rx_valid = 1'b0;
    int          low_cnt       = 0;
    int          high_cnt      = 0;
    int          rise_cnt      = 0;
    int          since_rise    = 0;
    int          frames_done   = 0;
    logic [15:0] cap           = 16'h0000;
    logic [15:0] miso_sr       = 16'h0000;
    bit          gap_armed     = 1'b0;
    bit          expect_abort  = 1'b0;

    spi_pwm_master #(
        .CLK_DIV   (CLK_DIV),
        .FRAME_BITS(FRAME_BITS)
    ) dut (
        .MainCLK  (MainCLK),
        .RST      (RST),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data (cmd_data),
        .CS       (CS),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    always #5 MainCLK = ~MainCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, then run the slave model and frame monitor.
    task automatic tick();
        logic [15:0] exp_w;
        @(negedge MainCLK);
        since_rise++;

        if (CS && prev_cs && (SCLK !== prev_sclk))
            chk("sclk_toggle_cs_high", 32'(SCLK), 32'(prev_sclk));

        if (prev_cs && !CS) begin
            if (gap_armed) begin
                chk("b2b_cs_high_cycles", 32'(high_cnt), 32'(CLK_DIV + 1));
                gap_armed = 1'b0;
            end
            low_cnt  = 1;
            rise_cnt = 0;
            cap      = 16'h0000;
            miso_sr  = (miso_q.size() > 0) ? miso_q.pop_front() : 16'h0000;
            MISO     = miso_sr[15];
        end else if (!CS) begin
            low_cnt++;
        end

        if (!CS && !prev_sclk && SCLK) begin
            if (rise_cnt > 0)
                chk("sclk_period", 32'(since_rise), 32'(2 * CLK_DIV));
            rise_cnt++;
            since_rise = 0;
            cap = {cap[14:0], MOSI};
        end

        if (!CS && prev_sclk && !SCLK) begin
            miso_sr = miso_sr << 1;
            MISO    = miso_sr[15];
        end

        if (!prev_cs && CS) begin
            high_cnt = 1;
            MISO     = 1'b0;
            if (expect_abort) begin
                chk("abort_sclk_low", 32'(SCLK), 32'd0);
                chk("abort_no_rx_valid", 32'(rx_valid), 32'd0);
                expect_abort = 1'b0;
            end else begin
                frames_done++;
                exp_w = (exp_tx_q.size() > 0) ? exp_tx_q.pop_front() : 16'hxxxx;
                chk("tx_frame", 32'(cap), 32'(exp_w));
                chk("cs_low_cycles", 32'(low_cnt), 32'(CS_LOW_CYC));
                chk("sclk_rises", 32'(rise_cnt), 32'(FRAME_BITS));
                chk("mosi_low_after_frame", 32'(MOSI), 32'd0);
                chk("rx_valid_at_cs_rise", 32'(rx_valid), 32'd1);
            end
        end else if (CS) begin
            high_cnt++;
        end

        if (rx_valid === 1'b1) begin
            exp_w = (exp_rx_q.size() > 0) ? exp_rx_q.pop_front() : 16'hxxxx;
            chk("rx_data", 32'(rx_data), 32'(exp_w));
            chk("rx_valid_with_cs_high", 32'(CS), 32'd1);
            if (prev_rx_valid)
                chk("rx_valid_one_cycle", 32'({prev_rx_valid, rx_valid}), 32'b01);
        end

        prev_cs       = CS;
        prev_sclk     = SCLK;
        prev_rx_valid = rx_valid;
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        while (cmd_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (cmd_ready !== 1'b1)
            chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int n;

        // Reset then idle
        RST = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        tick();
        chk("reset_cs", 32'(CS), 32'd1);
        chk("reset_sclk", 32'(SCLK), 32'd0);
        chk("reset_mosi", 32'(MOSI), 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);

        // Single write with readback; cmd_data is scrambled after acceptance
        cmd_data  = 16'h0380;
        cmd_valid = 1'b1;
        exp_tx_q.push_back(16'h0380);
        exp_rx_q.push_back(16'hA5C3);
        miso_q.push_back(16'hA5C3);
        tick();
        chk("accept_cs_low", 32'(CS), 32'd0);
        chk("accept_mosi_msb", 32'(MOSI), 32'd0);
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_ready_low", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        cmd_data  = 16'hFFFF;
        wait_ready(400, n);
        chk("handshake_cycles", 32'(n + 1), 32'(HS_CYC));
        chk("frames_after_single", 32'(frames_done), 32'd1);

        // Back-to-back with cmd_valid held high
        cmd_data  = 16'h0140;
        cmd_valid = 1'b1;
        exp_tx_q.push_back(16'h0140);
        exp_rx_q.push_back(16'h5A3C);
        miso_q.push_back(16'h5A3C);
        exp_tx_q.push_back(16'h02FF);
        exp_rx_q.push_back(16'h0FF0);
        miso_q.push_back(16'h0FF0);
        tick();
        cmd_data  = 16'h02FF;
        gap_armed = 1'b1;
        wait_ready(400, n);
        tick();
        chk("b2b_second_accepted", 32'(CS), 32'd0);
        cmd_valid = 1'b0;
        wait_ready(400, n);
        chk("frames_after_b2b", 32'(frames_done), 32'd3);
        chk("b2b_gap_seen", 32'(gap_armed), 32'd0);

        // Command pulsed while busy is ignored
        cmd_data  = 16'h1234;
        cmd_valid = 1'b1;
        exp_tx_q.push_back(16'h1234);
        exp_rx_q.push_back(16'hC33C);
        miso_q.push_back(16'hC33C);
        tick();
        cmd_valid = 1'b0;
        repeat (40) tick();
        cmd_data  = 16'hFFFF;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_ready(400, n);
        repeat (10) tick();
        chk("busy_reject_cs_high", 32'(CS), 32'd1);
        chk("busy_reject_idle", 32'(busy), 32'd0);
        chk("frames_after_reject", 32'(frames_done), 32'd4);

        // Reset after the 7th SCLK rise, with a command presented under reset
        cmd_data  = 16'h7E81;
        cmd_valid = 1'b1;
        miso_q.push_back(16'hFFFF);
        tick();
        cmd_valid    = 1'b0;
        expect_abort = 1'b1;
        n = 0;
        while (rise_cnt < 7 && n < 200) begin
            tick();
            n++;
        end
        if (rise_cnt < 7)
            chk("abort_wait_rise7", 32'(rise_cnt), 32'd7);
        RST       = 1'b1;
        cmd_valid = 1'b1;
        cmd_data  = 16'h0455;
        tick();
        chk("abort_cs_high", 32'(CS), 32'd1);
        chk("abort_sclk_now", 32'(SCLK), 32'd0);
        chk("abort_mosi_low", 32'(MOSI), 32'd0);
        chk("abort_rx_valid_now", 32'(rx_valid), 32'd0);
        chk("abort_rx_data_cleared", 32'(rx_data), 32'd0);
        chk("abort_seen", 32'(expect_abort), 32'd0);
        RST = 1'b0;
        exp_tx_q.push_back(16'h0455);
        exp_rx_q.push_back(16'h3C5A);
        miso_q.push_back(16'h3C5A);
        tick();
        chk("fresh_accept_cs_low", 32'(CS), 32'd0);
        cmd_valid = 1'b0;
        wait_ready(400, n);
        chk("frames_after_abort", 32'(frames_done), 32'd5);
        chk("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
        chk("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
